// File: rtl/somador_serial_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder/subtractor.
interface somador_serial_if #(
  parameter int unsigned N = 8
);
  logic         inicio;
  logic         sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Te;
  logic [N-1:0] S;
  logic         Ts;
  logic         ocupado;
  logic         pronto;

  modport master (
    output inicio, sub, A, B, Te,
    input  S, Ts, ocupado, pronto
  );

  modport slave (
    input  inicio, sub, A, B, Te,
    output S, Ts, ocupado, pronto
  );
endinterface

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock, LSB first, under a start/done handshake.
module somador_serial #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  somador_serial_if.slave bus
);

  localparam int unsigned CW = (N <= 1) ? 1 : $clog2(N);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SOMANDO = 2'd1,
    FIM     = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [N-1:0]  ra_q, ra_n;
  logic [N-1:0]  rb_q, rb_n;
  logic [N-1:0]  rs_q, rs_n;
  logic [N-1:0]  s_q, s_n;
  logic          carry_q, carry_n;
  logic          ts_q, ts_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          ocupado_q, ocupado_n;
  logic          pronto_q, pronto_n;
  logic          sum_c;
  logic          cout_c;

  // Full-adder cell on the current LSBs
  assign sum_c  = ra_q[0] ^ rb_q[0] ^ carry_q;
  assign cout_c = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);

  always_comb begin
    state_n   = state_q;
    ra_n      = ra_q;
    rb_n      = rb_q;
    rs_n      = rs_q;
    s_n       = s_q;
    carry_n   = carry_q;
    ts_n      = ts_q;
    cnt_n     = cnt_q;

    case (state_q)
      OCIOSO: begin
        if (bus.inicio) begin
          // Subtraction as A + ~B + ~Te; Ts then reads as "no borrow"
          ra_n    = bus.A;
          rb_n    = bus.sub ? ~bus.B : bus.B;
          carry_n = bus.sub ? ~bus.Te : bus.Te;
          cnt_n   = '0;
          state_n = SOMANDO;
        end
      end
      SOMANDO: begin
        carry_n = cout_c;
        ra_n    = ra_q >> 1;
        rb_n    = rb_q >> 1;
        rs_n    = (rs_q >> 1) | (N'(sum_c) << (N - 1));
        cnt_n   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          s_n     = rs_n;
          ts_n    = cout_c;
          state_n = FIM;
        end
      end
      FIM: begin
        state_n = OCIOSO;
      end
      default: begin
        state_n = OCIOSO;
      end
    endcase

    ocupado_n = (state_n == SOMANDO);
    pronto_n  = (state_n == FIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= OCIOSO;
      ra_q      <= '0;
      rb_q      <= '0;
      rs_q      <= '0;
      s_q       <= '0;
      carry_q   <= 1'b0;
      ts_q      <= 1'b0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      ra_q      <= ra_n;
      rb_q      <= rb_n;
      rs_q      <= rs_n;
      s_q       <= s_n;
      carry_q   <= carry_n;
      ts_q      <= ts_n;
      cnt_q     <= cnt_n;
      ocupado_q <= ocupado_n;
      pronto_q  <= pronto_n;
    end
  end

  assign bus.S       = s_q;
  assign bus.Ts      = ts_q;
  assign bus.ocupado = ocupado_q;
  assign bus.pronto  = pronto_q;

endmodule
